ysyx_25020047_lsu: RTL and testbench
====================================

Name: ysyx_25020047_lsu

Overview:
Load/store unit sitting directly upstream of the write-back unit. It accepts one memory operation from the execute stage, drives a single-outstanding request/response data-memory port, and aligns and extends load data. It hands the result to write-back as memdata, with a valid/ready handshake on both sides. Non-memory instructions pass through with memdata = 0.

Parameters:
TIMEOUT, 255, WAIT-state cycles without a response before the operation is aborted with err; valid range 1..65535.

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  execute stage presents an operation
in_ready  out  1  LSU can accept an operation
is_load  in  1  operation is a load
is_store  in  1  operation is a store; is_load and is_store are never both 1
funct3  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
addr  in  32  effective address (ALU result)
st_data  in  32  store data (rs2)
out_valid  out  1  memdata/err valid toward write-back
out_ready  in  1  write-back consumes the result
memdata  out  32  aligned, extended load data; 0 for stores and non-memory operations
err  out  1  misaligned access, illegal funct3, or timeout
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts the request
mem_we  out  1  1 = write
mem_addr  out  32  word address, {addr[31:2],2'b00}
mem_wdata  out  32  store data shifted to its byte lane
mem_wmask  out  4  byte-enable mask
mem_resp_valid  in  1  read data or write acknowledge
mem_rdata  in  32  read word

Behaviour:
- States: IDLE, REQ, WAIT, DONE. Reset (rst_n=0, asynchronous) forces IDLE and zeroes all outputs, the latched operation, and the timeout counter.
- IDLE:
  - in_ready=1; all other outputs 0.
  - On in_valid&&in_ready, latch is_load, is_store, funct3, addr and st_data.
  - Illegal funct3 (load: 011/110/111; store: anything but 000/001/010) -> DONE with err=1.
  - Misaligned access (h/hu with addr[0]=1; w with addr[1:0]!=0) -> DONE with err=1. No memory request is issued in either error case.
  - Neither load nor store -> DONE with memdata=0, err=0.
  - Otherwise -> REQ.
- in_ready=0 in REQ, WAIT and DONE.
- REQ:
  - mem_req_valid=1. mem_we, mem_addr, mem_wdata and mem_wmask are held stable until mem_req_ready.
  - Request handshake completes on mem_req_valid&&mem_req_ready; then -> WAIT with the counter cleared.
- Store lane rules (k = addr[1:0]):
  - sb: mask = 0001<<k, wdata = st_data[7:0] replicated into all four byte lanes.
  - sh: mask = 0011<<k, wdata = {2{st_data[15:0]}}.
  - sw: mask = 1111, wdata = st_data.
  - Loads: mask = 0000, mem_we=0.
- WAIT:
  - mem_resp_valid is sampled only in WAIT; a response arriving in REQ or IDLE is ignored.
  - On response, a load selects byte mem_rdata[8k+7:8k] or half mem_rdata[16*addr[1]+15:16*addr[1]], sign-extends for b/h and zero-extends for bu/hu, registers the result into memdata, and goes -> DONE. A store sets memdata=0 and goes -> DONE.
  - The counter increments each WAIT cycle without a response. When it reaches TIMEOUT: -> DONE with err=1, memdata=0.
  - A response in the same cycle the counter reaches TIMEOUT wins (no err).
- DONE:
  - out_valid=1. memdata and err are held stable until out_ready.
  - On out_ready -> IDLE, with out_valid, memdata and err cleared next cycle.
- Latency: at least 4 cycles per memory operation (1 IDLE accept, 1 REQ, 1 WAIT, 1 DONE); 2 cycles for non-memory or error operations.
- Reset mid-operation: an outstanding request or response is abandoned, and a late mem_resp_valid is ignored in IDLE.

Test Plan:
- Load, lb at addr 0x80000003 with mem_rdata=0x85FFFFFF, mem_req_ready and mem_resp_valid each one cycle after asserted -> mem_addr=0x80000000, memdata=0xFFFFFF85, err=0, out_valid high 4 cycles after in_valid accept.
- Load, lhu at 0x80000002 with rdata=0xBEEF1234 -> memdata=0x0000BEEF; lh at the same address -> memdata=0xFFFFBEEF.
- Store, sb st_data=0x000000AB at 0x80000102 -> mem_we=1, mem_wmask=0100, mem_wdata=0xABABABAB; sw at 0x80000100 -> mask=1111, wdata=st_data; memdata=0.
- Misaligned and illegal accesses:
  - lw at 0x80000002 -> no mem_req_valid ever, out_valid next cycle with err=1, memdata=0.
  - Load with funct3=011 -> err=1.
- Back-pressure and timeout:
  - mem_req_ready low for 5 cycles -> request fields stable throughout.
  - out_ready low for 3 cycles -> memdata held, in_ready=0.
  - No response with TIMEOUT=4 -> err=1 after 4 WAIT cycles.
- Reset: rst_n pulsed low during WAIT -> all outputs 0 immediately; a subsequent mem_resp_valid produces no out_valid; the next operation completes normally.

Source files
------------

// File: rtl/ysyx_25020047_lsu_if.sv
// Bundles the execute, write-back and data-memory handshakes of the LSU.
// The master modport is the LSU's view; slave is the surrounding pipeline and memory.
interface ysyx_25020047_lsu_if;
    logic        in_valid;
    logic        in_ready;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] st_data;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] memdata;
    logic        err;

    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;

    modport master (
        input  in_valid, is_load, is_store, funct3, addr, st_data,
        input  out_ready, mem_req_ready, mem_resp_valid, mem_rdata,
        output in_ready, out_valid, memdata, err,
        output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask
    );

    modport slave (
        output in_valid, is_load, is_store, funct3, addr, st_data,
        output out_ready, mem_req_ready, mem_resp_valid, mem_rdata,
        input  in_ready, out_valid, memdata, err,
        input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/ysyx_25020047_lsu.sv
// Load/store unit: one operation at a time, single-outstanding memory port,
// load alignment/extension and a response timeout, feeding write-back.
module ysyx_25020047_lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input logic                 clk,
    input logic                 rst_n,
    ysyx_25020047_lsu_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state;
    logic        op_load;
    logic        op_store;
    logic [2:0]  op_funct3;
    logic [31:0] op_addr;
    logic [31:0] op_st_data;
    logic [15:0] wait_cnt;

    logic        in_ready_q;
    logic        req_valid_q;
    logic        out_valid_q;
    logic        err_q;
    logic [31:0] memdata_q;

    logic        accept;
    logic        timeout_hit;

    function automatic logic access_err(input logic ld, input logic st,
                                        input logic [2:0] f3, input logic [1:0] a);
        logic illegal;
        logic misaligned;
        if (ld)      illegal = (f3 == 3'b011) || (f3[2:1] == 2'b11);
        else if (st) illegal = f3[2] || (f3[1:0] == 2'b11);
        else         illegal = 1'b0;
        misaligned = (ld || st) &&
                     (((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00)));
        return illegal || misaligned;
    endfunction

    function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] k);
        case (size)
            2'b00:   return 4'b0001 << k;
            2'b01:   return 4'b0011 << k;
            default: return 4'b1111;
        endcase
    endfunction

    // Narrow stores replicate across lanes; the mask picks the live bytes.
    function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] load_align(input logic [2:0] f3, input logic [1:0] k,
                                               input logic [31:0] rdata);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] ext;
        b = 8'(rdata >> {k, 3'b000});
        h = k[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            3'b000:  ext = 32'(b);
            3'b001:  ext = 32'(h);
            3'b100:  ext = {24'b0, b};
            3'b101:  ext = {16'b0, h};
            default: ext = rdata;
        endcase
        return ext;
    endfunction

    assign accept      = bus.in_valid && in_ready_q;
    assign timeout_hit = ({1'b0, wait_cnt} + 17'd1) == 17'(TIMEOUT);

    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.err           = err_q;
    assign bus.memdata       = memdata_q;
    assign bus.mem_req_valid = req_valid_q;
    // Request fields come straight from the latched operation, so they hold while REQ stalls.
    assign bus.mem_we        = req_valid_q && op_store;
    assign bus.mem_addr      = req_valid_q ? {op_addr[31:2], 2'b00} : 32'd0;
    assign bus.mem_wmask     = (req_valid_q && op_store) ? store_mask(op_funct3[1:0], op_addr[1:0]) : 4'd0;
    assign bus.mem_wdata     = (req_valid_q && op_store) ? store_wdata(op_funct3[1:0], op_st_data) : 32'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            op_load     <= 1'b0;
            op_store    <= 1'b0;
            op_funct3   <= 3'd0;
            op_addr     <= 32'd0;
            op_st_data  <= 32'd0;
            wait_cnt    <= 16'd0;
            in_ready_q  <= 1'b0;
            req_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            memdata_q   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        op_load    <= bus.is_load;
                        op_store   <= bus.is_store;
                        op_funct3  <= bus.funct3;
                        op_addr    <= bus.addr;
                        op_st_data <= bus.st_data;
                        in_ready_q <= 1'b0;
                        if (access_err(bus.is_load, bus.is_store, bus.funct3, bus.addr[1:0])) begin
                            state       <= DONE;
                            out_valid_q <= 1'b1;
                            err_q       <= 1'b1;
                        end else if (!bus.is_load && !bus.is_store) begin
                            state       <= DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state       <= REQ;
                            req_valid_q <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (bus.mem_req_ready) begin
                        state       <= WAIT;
                        req_valid_q <= 1'b0;
                        wait_cnt    <= 16'd0;
                    end
                end
                WAIT: begin
                    // A response on the timeout cycle still wins.
                    if (bus.mem_resp_valid) begin
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                        memdata_q   <= op_load ? load_align(op_funct3, op_addr[1:0], bus.mem_rdata) : 32'd0;
                    end else if (timeout_hit) begin
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                        err_q       <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        err_q       <= 1'b0;
                        memdata_q   <= 32'd0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_25020047_lsu.sv
// Directed bench for the LSU: loads, stores, error paths, back-pressure,
// timeout and asynchronous reset, with hand-computed expectations.
module tb_ysyx_25020047_lsu;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    ysyx_25020047_lsu_if bus();

    ysyx_25020047_lsu #(.TIMEOUT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Present one operation for a single accept cycle; returns at the next falling edge.
    task automatic issue_op(input logic ld, input logic st, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] d);
        bus.in_valid = 1'b1;
        bus.is_load  = ld;
        bus.is_store = st;
        bus.funct3   = f3;
        bus.addr     = a;
        bus.st_data  = d;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.is_load  = 1'b0;
        bus.is_store = 1'b0;
    endtask

    // From REQ: immediate request accept, then one-cycle response; ends in DONE.
    task automatic finish_mem(input logic [31:0] rdata);
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = rdata;
        @(negedge clk);
        bus.mem_resp_valid = 1'b0;
    endtask

    task automatic retire();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.err, bus.mem_req_valid, bus.mem_we} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl got %b want 00000",
                               {bus.in_ready, bus.out_valid, bus.err, bus.mem_req_valid, bus.mem_we});
        end
        checks++;
        if (bus.memdata !== 32'd0) begin errors++; $display("FAIL reset_memdata got %h want 0", bus.memdata); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_load_byte();
        issue_op(1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'd0);
        checks++;
        if (bus.mem_req_valid !== 1'b1 || bus.mem_addr !== 32'h8000_0000 || bus.mem_we !== 1'b0 ||
            bus.mem_wmask !== 4'b0000) begin
            errors++; $display("FAIL lb_req got v=%b a=%h we=%b m=%b want 1 80000000 0 0000",
                               bus.mem_req_valid, bus.mem_addr, bus.mem_we, bus.mem_wmask);
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL lb_busy got in_ready=%b want 0", bus.in_ready); end
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        checks++;
        if (bus.mem_req_valid !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL lb_wait got req=%b ov=%b want 0 0", bus.mem_req_valid, bus.out_valid);
        end
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h85FF_FFFF;
        @(negedge clk);
        bus.mem_resp_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.memdata !== 32'hFFFF_FF85 || bus.err !== 1'b0) begin
            errors++; $display("FAIL lb_done got ov=%b md=%h err=%b want 1 ffffff85 0",
                               bus.out_valid, bus.memdata, bus.err);
        end
        retire();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.memdata !== 32'd0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL lb_retire got ov=%b md=%h rdy=%b want 0 0 1",
                               bus.out_valid, bus.memdata, bus.in_ready);
        end
    endtask

    task automatic test_load_half();
        issue_op(1'b1, 1'b0, 3'b101, 32'h8000_0002, 32'd0);
        finish_mem(32'hBEEF_1234);
        checks++;
        if (bus.memdata !== 32'h0000_BEEF || bus.err !== 1'b0) begin
            errors++; $display("FAIL lhu got md=%h err=%b want 0000beef 0", bus.memdata, bus.err);
        end
        retire();
        issue_op(1'b1, 1'b0, 3'b001, 32'h8000_0002, 32'd0);
        finish_mem(32'hBEEF_1234);
        checks++;
        if (bus.memdata !== 32'hFFFF_BEEF) begin errors++; $display("FAIL lh got %h want ffffbeef", bus.memdata); end
        retire();
        issue_op(1'b1, 1'b0, 3'b100, 32'h8000_0001, 32'd0);
        finish_mem(32'h1122_3344);
        checks++;
        if (bus.memdata !== 32'h0000_0033) begin errors++; $display("FAIL lbu got %h want 00000033", bus.memdata); end
        retire();
    endtask

    task automatic test_store();
        issue_op(1'b0, 1'b1, 3'b000, 32'h8000_0102, 32'h0000_00AB);
        checks++;
        if (bus.mem_we !== 1'b1 || bus.mem_wmask !== 4'b0100 || bus.mem_wdata !== 32'hABAB_ABAB ||
            bus.mem_addr !== 32'h8000_0100) begin
            errors++; $display("FAIL sb got we=%b m=%b d=%h a=%h want 1 0100 abababab 80000100",
                               bus.mem_we, bus.mem_wmask, bus.mem_wdata, bus.mem_addr);
        end
        finish_mem(32'hFFFF_FFFF);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.memdata !== 32'd0 || bus.err !== 1'b0) begin
            errors++; $display("FAIL sb_done got ov=%b md=%h err=%b want 1 0 0", bus.out_valid, bus.memdata, bus.err);
        end
        retire();
        issue_op(1'b0, 1'b1, 3'b001, 32'h8000_0102, 32'h0000_CAFE);
        checks++;
        if (bus.mem_wmask !== 4'b1100 || bus.mem_wdata !== 32'hCAFE_CAFE) begin
            errors++; $display("FAIL sh got m=%b d=%h want 1100 cafecafe", bus.mem_wmask, bus.mem_wdata);
        end
        finish_mem(32'd0);
        retire();
        issue_op(1'b0, 1'b1, 3'b010, 32'h8000_0100, 32'h1234_5678);
        checks++;
        if (bus.mem_wmask !== 4'b1111 || bus.mem_wdata !== 32'h1234_5678) begin
            errors++; $display("FAIL sw got m=%b d=%h want 1111 12345678", bus.mem_wmask, bus.mem_wdata);
        end
        finish_mem(32'hDEAD_0000);
        checks++;
        if (bus.memdata !== 32'd0) begin errors++; $display("FAIL sw_done got md=%h want 0", bus.memdata); end
        retire();
    endtask

    task automatic test_misaligned();
        logic [2:0]  f3s [5]   = '{3'b010, 3'b001, 3'b011, 3'b100, 3'b000};
        logic [31:0] addrs [5] = '{32'h8000_0002, 32'h8000_0001, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
        logic        lds [5]   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic        sts [5]   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic        errs [5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            issue_op(lds[i], sts[i], f3s[i], addrs[i], 32'hFFFF_FFFF);
            checks++;
            if (bus.mem_req_valid !== 1'b0 || bus.out_valid !== 1'b1 || bus.err !== errs[i] ||
                bus.memdata !== 32'd0) begin
                errors++; $display("FAIL err_case%0d got req=%b ov=%b err=%b md=%h want 0 1 %b 0",
                                   i, bus.mem_req_valid, bus.out_valid, bus.err, bus.memdata, errs[i]);
            end
            retire();
        end
    endtask

    task automatic test_req_backpressure();
        issue_op(1'b0, 1'b1, 3'b010, 32'h8000_0024, 32'hDEAD_BEEF);
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h5555_5555;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.mem_req_valid !== 1'b1 || bus.mem_addr !== 32'h8000_0024 || bus.mem_we !== 1'b1 ||
                bus.mem_wdata !== 32'hDEAD_BEEF || bus.mem_wmask !== 4'b1111 || bus.out_valid !== 1'b0) begin
                errors++; $display("FAIL req_stall%0d got v=%b a=%h we=%b d=%h m=%b ov=%b", i,
                                   bus.mem_req_valid, bus.mem_addr, bus.mem_we, bus.mem_wdata,
                                   bus.mem_wmask, bus.out_valid);
            end
        end
        bus.mem_resp_valid = 1'b0;
        bus.mem_req_ready  = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL early_resp got ov=%b want 0", bus.out_valid); end
        bus.mem_resp_valid = 1'b1;
        @(negedge clk);
        bus.mem_resp_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.err !== 1'b0) begin
            errors++; $display("FAIL stall_done got ov=%b err=%b want 1 0", bus.out_valid, bus.err);
        end
        retire();
    endtask

    task automatic test_out_backpressure();
        issue_op(1'b1, 1'b0, 3'b100, 32'h8000_0001, 32'd0);
        finish_mem(32'h1122_3344);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.memdata !== 32'h0000_0033 || bus.in_ready !== 1'b0) begin
                errors++; $display("FAIL out_stall%0d got ov=%b md=%h rdy=%b want 1 00000033 0",
                                   i, bus.out_valid, bus.memdata, bus.in_ready);
            end
        end
        retire();
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL out_release got ov=%b want 0", bus.out_valid); end
    endtask

    task automatic test_timeout(input logic late_resp);
        issue_op(1'b1, 1'b0, 3'b010, 32'h8000_0040, 32'd0);
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++; $display("FAIL to_wait%0d got ov=%b want 0", i, bus.out_valid);
            end
        end
        bus.mem_resp_valid = late_resp;
        bus.mem_rdata      = 32'h0BAD_F00D;
        @(negedge clk);
        bus.mem_resp_valid = 1'b0;
        checks++;
        if (late_resp) begin
            if (bus.out_valid !== 1'b1 || bus.err !== 1'b0 || bus.memdata !== 32'h0BAD_F00D) begin
                errors++; $display("FAIL to_tie got ov=%b err=%b md=%h want 1 0 0badf00d",
                                   bus.out_valid, bus.err, bus.memdata);
            end
        end else begin
            if (bus.out_valid !== 1'b1 || bus.err !== 1'b1 || bus.memdata !== 32'd0) begin
                errors++; $display("FAIL to_expire got ov=%b err=%b md=%h want 1 1 0",
                                   bus.out_valid, bus.err, bus.memdata);
            end
        end
        retire();
    endtask

    task automatic test_reset_mid();
        issue_op(1'b0, 1'b1, 3'b000, 32'h8000_0005, 32'h0000_0077);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.mem_req_valid !== 1'b0 || bus.mem_addr !== 32'd0 || bus.mem_wmask !== 4'd0) begin
            errors++; $display("FAIL rst_req got v=%b a=%h m=%b want 0 0 0",
                               bus.mem_req_valid, bus.mem_addr, bus.mem_wmask);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue_op(1'b1, 1'b0, 3'b010, 32'h8000_0010, 32'd0);
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.err, bus.mem_req_valid, bus.memdata} !== 36'd0) begin
            errors++; $display("FAIL rst_wait got rdy=%b ov=%b err=%b req=%b md=%h want all 0",
                               bus.in_ready, bus.out_valid, bus.err, bus.mem_req_valid, bus.memdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'hAAAA_AAAA;
        @(negedge clk);
        bus.mem_resp_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL rst_late_resp got ov=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready);
        end
        issue_op(1'b1, 1'b0, 3'b001, 32'h8000_0000, 32'd0);
        finish_mem(32'h0000_8001);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.memdata !== 32'hFFFF_8001 || bus.err !== 1'b0) begin
            errors++; $display("FAIL rst_recover got ov=%b md=%h err=%b want 1 ffff8001 0",
                               bus.out_valid, bus.memdata, bus.err);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.memdata !== 32'd0) begin
            errors++; $display("FAIL rst_done got ov=%b md=%h want 0 0", bus.out_valid, bus.memdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        bus.in_valid       = 1'b0;
        bus.is_load        = 1'b0;
        bus.is_store       = 1'b0;
        bus.funct3         = 3'd0;
        bus.addr           = 32'd0;
        bus.st_data        = 32'd0;
        bus.out_ready      = 1'b0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = 32'd0;
        rst_n              = 1'b0;
        test_reset();
        test_load_byte();
        test_load_half();
        test_store();
        test_misaligned();
        test_req_backpressure();
        test_out_backpressure();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired after %0d checks", checks);
        $fatal(1);
    end
endmodule
